// File: rtl/pkg_mips.sv
// Shared definitions for the MIPS fetch path: word width, memory size and fetch states.
package pkg_mips;

    localparam int PALAVRA_W      = 32;
    localparam int TAM_MEM_PADRAO = 32;

    typedef enum logic [1:0] {
        PARADO   = 2'd0,
        BUSCANDO = 2'd1,
        FIM      = 2'd2
    } estado_t;

endpackage

// File: rtl/fila_instrucao.sv
// Two-entry synchronous FIFO holding {pc, instrucao} pairs; flush beats push and pop.
module fila_instrucao #(
    parameter int DATA_W = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] dado,
    output logic [1:0]        count,
    output logic [DATA_W-1:0] cabeca
);

    logic [DATA_W-1:0] slot0;
    logic [DATA_W-1:0] slot1;
    logic              pop_ef;
    logic              push_ef;
    logic [1:0]        ocupacao;

    assign pop_ef   = pop && (count != 2'd0) && !flush;
    assign push_ef  = push && !flush && ((count != 2'd2) || pop_ef);
    assign ocupacao = count - {1'b0, pop_ef};
    assign cabeca   = (count == 2'd0) ? '0 : slot0;

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            count <= 2'd0;
        end else begin
            case ({push_ef, pop_ef})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Head always lives in slot0; a pop shifts slot1 forward before the new entry lands.
    always_ff @(posedge clock) begin
        if (pop_ef) begin
            slot0 <= slot1;
        end
        if (push_ef) begin
            if (ocupacao == 2'd0) begin
                slot0 <= dado;
            end else begin
                slot1 <= dado;
            end
        end
    end

endmodule

// File: rtl/unidade_busca.sv
// Instruction-fetch controller: owns the PC, fills the two-entry buffer and applies redirects.
module unidade_busca
    import pkg_mips::*;
#(
    parameter int          TAM_MEM     = TAM_MEM_PADRAO,
    parameter logic [31:0] END_INICIAL = 32'd0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        habilita,
    output logic [31:0] endMem,
    input  logic [31:0] instrucaoMem,
    input  logic        desvio,
    input  logic [31:0] endDesvio,
    output logic        valido,
    input  logic        pronto,
    output logic [31:0] instrucao,
    output logic [31:0] pcSaida,
    output logic        fim,
    output logic        erro
);

    localparam logic [31:0] LIMITE = 32'(TAM_MEM);
    localparam logic [31:0] ULTIMO = 32'(TAM_MEM - 1);

    estado_t     estado;
    estado_t     estado_prox;
    logic [31:0] pc;
    logic [31:0] pc_prox;
    logic        erro_prox;
    logic        push;
    logic        pop;
    logic [1:0]  count;
    logic [63:0] cabeca;

    assign endMem    = pc;
    assign valido    = (count != 2'd0);
    assign pop       = valido && pronto;
    assign pcSaida   = cabeca[63:32];
    assign instrucao = cabeca[31:0];
    assign fim       = (estado == FIM);

    // Fetching stops in the same cycle habilita drops, so a paused bench sees no surprise push.
    assign push = (estado == BUSCANDO) && habilita && !desvio &&
                  ((count != 2'd2) || pop);

    always_comb begin
        estado_prox = estado;
        pc_prox     = pc;
        erro_prox   = erro;
        if (desvio) begin
            if (endDesvio < LIMITE) begin
                pc_prox = endDesvio;
                if (!habilita) begin
                    estado_prox = PARADO;
                end else if (estado == FIM) begin
                    estado_prox = BUSCANDO;
                end
            end else begin
                erro_prox   = 1'b1;
                estado_prox = FIM;
            end
        end else begin
            case (estado)
                PARADO: begin
                    if (habilita) estado_prox = BUSCANDO;
                end
                BUSCANDO: begin
                    if (!habilita) begin
                        estado_prox = PARADO;
                    end else if (push) begin
                        if (pc == ULTIMO) begin
                            estado_prox = FIM;
                        end else begin
                            pc_prox = pc + 32'd1;
                        end
                    end
                end
                default: estado_prox = FIM;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado <= PARADO;
            pc     <= END_INICIAL;
            erro   <= 1'b0;
        end else begin
            estado <= estado_prox;
            pc     <= pc_prox;
            erro   <= erro_prox;
        end
    end

    fila_instrucao #(
        .DATA_W(64)
    ) u_fila (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (desvio),
        .dado  ({pc, instrucaoMem}),
        .count (count),
        .cabeca(cabeca)
    );

endmodule

// File: tb/tb_unidade_busca.sv
// Directed and random stimulus for unidade_busca against a queue-based fetch model.
module tb_unidade_busca;

    logic        clock;
    logic        reset;
    logic        habilita;
    logic [31:0] endMem;
    logic [31:0] instrucaoMem;
    logic        desvio;
    logic [31:0] endDesvio;
    logic        valido;
    logic        pronto;
    logic [31:0] instrucao;
    logic [31:0] pcSaida;
    logic        fim;
    logic        erro;

    logic [31:0] mem [0:31];

    int vetores = 0;
    int erros   = 0;

    // Reference model: a queue of {pc, instr} plus run/stop/end flags.
    logic [63:0]  m_q[$];
    int unsigned  m_pc;
    bit           m_rodando;
    bit           m_fim;
    bit           m_erro;

    unidade_busca #(
        .TAM_MEM    (32),
        .END_INICIAL(32'd0)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .habilita    (habilita),
        .endMem      (endMem),
        .instrucaoMem(instrucaoMem),
        .desvio      (desvio),
        .endDesvio   (endDesvio),
        .valido      (valido),
        .pronto      (pronto),
        .instrucao   (instrucao),
        .pcSaida     (pcSaida),
        .fim         (fim),
        .erro        (erro)
    );

    assign instrucaoMem = (endMem < 32'd32) ? mem[endMem[4:0]] : 32'd0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        vetores++;
        assert (obs === esp) else begin
            erros++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, esp, $time);
        end
    endtask

    task automatic atualiza_modelo();
        bit pop;
        pop = (m_q.size() != 0) && pronto;
        if (reset) begin
            m_q.delete();
            m_pc      = 0;
            m_rodando = 0;
            m_fim     = 0;
            m_erro    = 0;
        end else if (desvio) begin
            m_q.delete();
            if (endDesvio < 32) begin
                m_pc = endDesvio;
                if (!habilita) begin
                    m_rodando = 0;
                    m_fim     = 0;
                end else if (m_fim) begin
                    m_fim     = 0;
                    m_rodando = 1;
                end
            end else begin
                m_erro    = 1;
                m_fim     = 1;
                m_rodando = 0;
            end
        end else if (m_fim) begin
            if (pop) void'(m_q.pop_front());
        end else if (!m_rodando) begin
            if (pop) void'(m_q.pop_front());
            if (habilita) m_rodando = 1;
        end else if (!habilita) begin
            if (pop) void'(m_q.pop_front());
            m_rodando = 0;
        end else begin
            bit ha_espaco;
            ha_espaco = (m_q.size() < 2) || pop;
            if (pop) void'(m_q.pop_front());
            if (ha_espaco) begin
                m_q.push_back({m_pc, m_pc + 32'd100});
                if (m_pc == 31) begin
                    m_fim     = 1;
                    m_rodando = 0;
                end else begin
                    m_pc++;
                end
            end
        end
    endtask

    task automatic confere();
        logic [63:0] cab;
        cab = (m_q.size() != 0) ? m_q[0] : 64'd0;
        verifica("valido",    {31'd0, valido}, {31'd0, m_q.size() != 0});
        verifica("pcSaida",   pcSaida,         cab[63:32]);
        verifica("instrucao", instrucao,       cab[31:0]);
        verifica("fim",       {31'd0, fim},    {31'd0, m_fim});
        verifica("erro",      {31'd0, erro},   {31'd0, m_erro});
        verifica("endMem",    endMem,          m_pc);
    endtask

    task automatic ciclo();
        atualiza_modelo();
        @(posedge clock);
        #1;
        confere();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'(i + 100);
        reset     = 1'b1;
        habilita  = 1'b0;
        desvio    = 1'b0;
        endDesvio = 32'd0;
        pronto    = 1'b1;
        m_pc = 0; m_rodando = 0; m_fim = 0; m_erro = 0;

        @(posedge clock); #1;
        ciclo(); ciclo();
        reset = 1'b0;
        ciclo();

        // Full stream to the end of memory
        habilita = 1'b1;
        repeat (36) ciclo();

        // Restart from FIM, then back-pressure mid-stream
        desvio = 1'b1; endDesvio = 32'd0; ciclo();
        desvio = 1'b0;
        repeat (5) ciclo();
        pronto = 1'b0;
        repeat (5) ciclo();
        pronto = 1'b1;
        repeat (4) ciclo();

        // Redirect while the buffer is full
        pronto = 1'b0;
        repeat (3) ciclo();
        desvio = 1'b1; endDesvio = 32'd7; ciclo();
        desvio = 1'b0; pronto = 1'b1;
        repeat (4) ciclo();

        // Out-of-range redirect, then recovery
        desvio = 1'b1; endDesvio = 32'd40; ciclo();
        desvio = 1'b0;
        repeat (3) ciclo();
        desvio = 1'b1; endDesvio = 32'd3; ciclo();
        desvio = 1'b0;
        repeat (4) ciclo();

        // Pause with two entries buffered, drain, resume
        pronto = 1'b0;
        repeat (3) ciclo();
        habilita = 1'b0;
        repeat (3) ciclo();
        pronto = 1'b1;
        repeat (3) ciclo();
        habilita = 1'b1;
        repeat (4) ciclo();

        // Reset with a full buffer
        pronto = 1'b0;
        repeat (3) ciclo();
        reset = 1'b1; ciclo();
        reset = 1'b0; habilita = 1'b0; ciclo();
        habilita = 1'b1; pronto = 1'b1;

        for (int n = 0; n < 500; n++) begin
            habilita  = ($urandom_range(0, 9) != 0);
            pronto    = ($urandom_range(0, 2) != 0);
            desvio    = ($urandom_range(0, 19) == 0);
            endDesvio = 32'($urandom_range(0, 45));
            reset     = ($urandom_range(0, 99) == 0);
            ciclo();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vetores, erros);
        $finish;
    end

endmodule

// File: doc/unidade_busca.md
# unidade_busca

Instruction-fetch controller for the single-cycle MIPS simulator. It owns the program counter, drives the word address of the 32-word combinational instruction memory, captures each returned instruction with its PC into a 2-entry buffer, and hands them to decode over a valid/ready handshake. It also applies branch/jump redirects (flushing buffered instructions) and stops at the end of program memory.

## Interface
- TAM_MEM, 32, number of instruction words; valid word addresses are 0..TAM_MEM-1
- END_INICIAL, 0, PC word address loaded on reset
- clock  in  1  single system clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high; sampled on the rising edge of clock
- habilita  in  1  run enable; 0 pauses fetching
- endMem  out  32  word address to the instruction memory; always equal to pc
- instrucaoMem  in  32  instruction returned by the memory for endMem, same cycle
- desvio  in  1  redirect request, one cycle
- endDesvio  in  32  redirect target word address, qualified by desvio
- valido  out  1  instrucao/pcSaida hold a buffered instruction
- pronto  in  1  decode accepts the head entry this cycle
- instrucao  out  32  head-of-buffer instruction
- pcSaida  out  32  word address of instrucao
- fim  out  1  fetch stopped at end of memory
- erro  out  1  sticky; a redirect targeted an address ≥ TAM_MEM

## Operation
- Reset values: pc=END_INICIAL, estado=PARADO, buffer empty, valido=0, instrucao=0, pcSaida=0, fim=0, erro=0.
- States: PARADO, BUSCANDO, FIM.
  - PARADO: no fetch. habilita=1 → BUSCANDO.
  - BUSCANDO: habilita=0 → PARADO (buffer contents kept). Fetch rule below.
  - FIM: fim=1; no fetch. Left only by an in-range redirect (→ BUSCANDO, fim=0) or reset.
- Fetch, in BUSCANDO with desvio=0: when the buffer has room (count<2, or count=2 with a pop this cycle), push {pc, instrucaoMem} and set pc=pc+1. If the pushed pc = TAM_MEM-1, go to FIM; pc stays TAM_MEM-1.
- Pop: valido && pronto removes the head. Head outputs are combinational from the buffer; they are 0 when empty.
- Redirect (desvio=1), priority over push and pop in every state:
  - Flush the buffer (count=0, no pop is counted) and suppress the push.
  - If endDesvio < TAM_MEM: pc=endDesvio. From FIM go to BUSCANDO. PARADO stays PARADO.
  - Else: erro=1, pc unchanged, go to FIM.
- Simultaneous habilita=0 and desvio: apply the redirect, then go to PARADO.
- Widths: pc is 32-bit unsigned. Comparisons use the full 32 bits, so no wrap-around occurs.

## Timing
- Memory read is combinational: endMem at cycle t, instrucaoMem valid in cycle t, captured at the edge ending t.
- habilita sampled 1 at edge k → BUSCANDO after k. First push at edge k+1, valido=1 after k+1.
- Throughput: 1 instruction per cycle with pronto held 1.
- Latency: pc to valido is 1 edge when the buffer is empty.
- Redirect sampled at edge r: valido=0 after r. The target's instruction is valid after r+1.
- Buffer full and pronto=0: pc and buffer are frozen; endMem is stable.
- Reset mid-operation overrides everything on that edge.

## Structure
- Package pkg_mips: the estado encoding (PARADO=2'd0, BUSCANDO=2'd1, FIM=2'd2), the 32-bit word width, and the default TAM_MEM.
- Sub-module fila_instrucao: 2-entry synchronous FIFO, 64-bit entries {pc, instrucao}, with push, pop, flush, count, and head outputs. Flush has priority.
- Top level holds pc, the state machine, and the push/redirect logic.

## Test plan
- Reset then habilita=1 with pronto=1 and memory preloaded with mem[i]=i+100: pcSaida/instrucao stream 0/100, 1/101, … one per cycle. After pcSaida=31, fim=1 and valido drops.
- pronto=0 for 5 cycles mid-stream: count saturates at 2 and endMem freezes. Release → entries pc=n, n+1 emerge in order with no loss or duplicate.
- desvio with endDesvio=7 while count=2: valido=0 on the next cycle, then pcSaida=7/instrucao=107. The flushed entries never appear.
- desvio with endDesvio=40: erro=1 and fim=1, stay sticky. A later desvio to 3 restarts at pcSaida=3 with erro still 1.
- habilita=0 with 2 entries buffered: no new fetch, and both entries still drain on pronto. habilita=1 resumes at the next pc.
- reset asserted while count=2 and estado=BUSCANDO: the next cycle shows valido=0, pc=END_INICIAL, estado=PARADO.
